// File: rtl/audio_pwm_player.sv
// Streams offset-binary samples from a latency-1 block RAM onto the PWM audio pin.
// Define AUD_PLAY_LOOP_EN to wrap the clip seamlessly instead of stopping at its end.
module audio_pwm_player #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 20,
  parameter int DEPTH      = 256,
  parameter int PWM_REPEAT = 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        vol,
  output logic [ADDR_W-1:0] addra,
  output logic              ena,
  input  logic [DATA_W-1:0] douta,
  output logic              AUD_PWM,
  output logic              AUD_SD,
  output logic              busy,
  output logic              done
);
  localparam int                REP_W    = (PWM_REPEAT > 1) ? $clog2(PWM_REPEAT) : 1;
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(PWM_REPEAT - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
`ifdef AUD_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic                ena_q, ena_d;
  logic [DATA_W-1:0]   duty_q, duty_d;
  logic [DATA_W-1:0]   next_q, next_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                rd_vld_q, rd_vld_d;
  logic                pwm_q, pwm_d;
  logic                sd_q, sd_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   shifted;
  logic                frame_end, sample_end, pf_last, pf_ok;
  logic [ADDR_W-1:0]   pf_addr;

  assign shifted    = douta >> vol;
  assign frame_end  = (cnt_q == '1);
  assign sample_end = frame_end && (rep_q == REP_LAST);
  // addra_q always holds the most recently fetched address, so the prefetch target follows it
  assign pf_last    = (addra_q == LAST);
  assign pf_addr    = pf_last ? '0 : addra_q + 1'b1;
  assign pf_ok      = LOOP || !pf_last;

  always_comb begin
    state_d  = state_q;
    addra_d  = addra_q;
    ena_d    = 1'b0;
    duty_d   = duty_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    idx_d    = idx_q;
    rd_vld_d = ena_q;
    pwm_d    = pwm_q;
    sd_d     = sd_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_FETCH;
          ena_d   = 1'b1;
          addra_d = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        duty_d  = shifted;
        cnt_d   = '0;
        rep_d   = '0;
        idx_d   = '0;
        sd_d    = 1'b1;
        state_d = S_PLAY;
        if (pf_ok) begin
          ena_d   = 1'b1;
          addra_d = pf_addr;
        end
      end
      S_PLAY: begin
        if (rd_vld_q) next_d = shifted;
        cnt_d = cnt_q + 1'b1;
        pwm_d = (cnt_q < duty_q);
        if (frame_end) rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
        if (sample_end) begin
          if (idx_q == LAST && !LOOP) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            sd_d    = 1'b0;
            pwm_d   = 1'b0;
            addra_d = '0;
          end else begin
            duty_d = next_q;
            idx_d  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (pf_ok) begin
              ena_d   = 1'b1;
              addra_d = pf_addr;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // stop overrides everything, including a natural end on the same edge
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ena_d   = 1'b0;
      sd_d    = 1'b0;
      pwm_d   = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= S_IDLE;
      addra_q  <= '0;
      ena_q    <= 1'b0;
      duty_q   <= '0;
      next_q   <= '0;
      cnt_q    <= '0;
      rep_q    <= '0;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
      pwm_q    <= 1'b0;
      sd_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addra_q  <= addra_d;
      ena_q    <= ena_d;
      duty_q   <= duty_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      idx_q    <= idx_d;
      rd_vld_q <= rd_vld_d;
      pwm_q    <= pwm_d;
      sd_q     <= sd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign addra   = addra_q;
  assign ena     = ena_q;
  assign AUD_PWM = pwm_q;
  assign AUD_SD  = sd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_audio_pwm_player.sv
// Bench for audio_pwm_player: directed clips plus random ROM/volume runs against a
// per-clock reference derived from sample value, volume and sample position.
module tb_audio_pwm_player;
  localparam int DW = 4, AW = 20, DEPTH = 4, REP = 2;
  localparam int FR = 1 << DW, SPS = FR * REP;
`ifdef AUD_PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0;
  logic [2:0]    vol = '0;
  logic [AW-1:0] addra;
  logic          ena, pwm, sd, busy, done;
  logic [DW-1:0] douta = '0;
  logic [DW-1:0] rom [DEPTH];
  int            vol_arr [DEPTH];
  int            n_chk = 0, n_fail = 0;

  audio_pwm_player #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PWM_REPEAT(REP)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start), .stop(stop), .vol(vol),
    .addra(addra), .ena(ena), .douta(douta), .AUD_PWM(pwm), .AUD_SD(sd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // block RAM, read latency 1
  always @(posedge clk) if (ena) douta <= rom[addra[1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_sd"}, sd, 0);
    chk({tag, "_pwm"}, pwm, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Plays one clip; i counts edges after the capture edge that raises AUD_SD.
  task automatic play_clip(input int stop_at, input int busy_start_at);
    int  total, k, j, d, m;
    bit  last, bnd, pf;
    total = SPS * DEPTH * (LOOP ? 2 : 1);
    if (LOOP && stop_at == 0) stop_at = total;
    vol = 3'(vol_arr[0]);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_ena", ena, 1); chk("start_addr", addra, 0);
    chk("start_busy", busy, 1); chk("start_sd", sd, 0);
    @(negedge clk);
    chk("fetch_ena", ena, 0); chk("fetch_sd", sd, 0);
    @(negedge clk);
    chk("wait_sd", sd, 1); chk("wait_ena", ena, 1); chk("wait_addr", addra, 1);
    chk("wait_pwm", pwm, 0); chk("wait_busy", busy, 1);
    vol = 3'(vol_arr[1 % DEPTH]);
    for (int i = 1; i <= total; i++) begin
      if (i == stop_at) stop = 1'b1;
      if (i == busy_start_at) start = 1'b1;
      @(negedge clk); stop = 1'b0; start = 1'b0;
      if (i == stop_at) begin
        chk_idle_outs("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort_done_after", done, 0); chk("abort_busy_after", busy, 0);
        end
        return;
      end
      k    = (i - 1) / SPS;
      j    = (i - 1) % SPS;
      d    = rom[k % DEPTH] >> vol_arr[k % DEPTH];
      last = !LOOP && (i == total);
      bnd  = (i % SPS == 0) && !last;
      m    = i / SPS;
      pf   = bnd && (LOOP || (m + 1 < DEPTH));
      chk("pwm", pwm, last ? 0 : ((j % FR) < d));
      chk("done", done, last);
      chk("sd", sd, !last);
      chk("busy", busy, !last);
      chk("ena", ena, pf);
      if (last) chk("end_addr", addra, 0);
      if (pf) chk("pf_addr", addra, (m + 1) % DEPTH);
      if (bnd) vol = 3'(vol_arr[(m + 1) % DEPTH]);
    end
  endtask

  initial begin
    rom[0] = 4'h0; rom[1] = 4'h8; rom[2] = 4'hF; rom[3] = 4'h3;
    foreach (vol_arr[i]) vol_arr[i] = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset"); chk("reset_addr", addra, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal clip, with a start pulse while busy that must be ignored
    play_clip(0, 70);
    repeat (2) @(negedge clk);

    // attenuation: 0x8>>3 = 1, 0xF>>1 = 7
    vol_arr[1] = 3; vol_arr[2] = 1;
    play_clip(0, 0);
    foreach (vol_arr[i]) vol_arr[i] = 0;

    // stop mid-sample 1, then restart from address 0
    play_clip(40, 0);
    play_clip(0, 0);

    // stop on the end-of-clip edge wins over done
    play_clip(SPS * DEPTH, 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0); chk("ss_ena", ena, 0);
    @(negedge clk);
    chk("ss_busy2", busy, 0); chk("ss_sd", sd, 0);

    // asynchronous reset mid-play
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_sd", sd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outs("arst"); chk("arst_addr", addra, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle_outs("post_rst");

    // random clips
    repeat (3) begin
      foreach (rom[i]) rom[i] = DW'($urandom_range(0, FR - 1));
      foreach (vol_arr[i]) vol_arr[i] = int'($urandom_range(0, 4));
      play_clip(0, 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
